// File: rtl/gpio_debounce.sv
// Multi-channel GPIO debouncer: 2-flop synchronizer, shared sample-tick prescaler and a
// per-channel four-state FSM that accepts a level after STABLE_TICKS stable ticks.
module gpio_debounce #(
  parameter int unsigned NUM_CH       = 9,
  parameter int unsigned TICK_DIV     = 1000,
  parameter int unsigned STABLE_TICKS = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] raw_in,
  output logic [NUM_CH-1:0] clean_out,
  output logic [NUM_CH-1:0] rise_pulse,
  output logic [NUM_CH-1:0] fall_pulse,
  output logic              any_event
);

  localparam int unsigned DivW = $clog2(TICK_DIV);
  localparam int unsigned CntW = (STABLE_TICKS > 1) ? $clog2(STABLE_TICKS) : 1;
  localparam logic [DivW-1:0] DivLast = DivW'(TICK_DIV - 1);
  localparam logic [CntW-1:0] CntLast = CntW'(STABLE_TICKS - 1);

  // Bit 1 of the encoding is the debounced level, so clean_out falls straight out of state.
  localparam logic [1:0] S_LOW       = 2'b00;
  localparam logic [1:0] S_WAIT_HIGH = 2'b01;
  localparam logic [1:0] S_HIGH      = 2'b11;
  localparam logic [1:0] S_WAIT_LOW  = 2'b10;

  logic [NUM_CH-1:0] sync1_q, sync_in;
  logic [DivW-1:0]   div_q;
  logic              tick;
  logic [1:0]        state_q [NUM_CH];
  logic [1:0]        state_d [NUM_CH];
  logic [CntW-1:0]   cnt_q   [NUM_CH];
  logic [CntW-1:0]   cnt_d   [NUM_CH];
  logic [NUM_CH-1:0] rise_d, fall_d, rise_q, fall_q;
  logic              any_q;

  assign tick = (div_q == DivLast);

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync_in <= '0;
      div_q   <= '0;
    end else begin
      sync1_q <= raw_in;
      sync_in <= sync1_q;
      div_q   <= tick ? '0 : div_q + 1'b1;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      rise_d[i]  = 1'b0;
      fall_d[i]  = 1'b0;
      unique case (state_q[i])
        S_LOW: begin
          if (sync_in[i]) begin
            state_d[i] = S_WAIT_HIGH;
            cnt_d[i]   = '0;
          end
        end
        S_WAIT_HIGH: begin
          // A bounce back to low takes priority over a coincident tick.
          if (!sync_in[i]) begin
            state_d[i] = S_LOW;
            cnt_d[i]   = '0;
          end else if (tick) begin
            if (cnt_q[i] == CntLast) begin
              state_d[i] = S_HIGH;
              cnt_d[i]   = '0;
              rise_d[i]  = 1'b1;
            end else begin
              cnt_d[i] = cnt_q[i] + 1'b1;
            end
          end
        end
        S_HIGH: begin
          if (!sync_in[i]) begin
            state_d[i] = S_WAIT_LOW;
            cnt_d[i]   = '0;
          end
        end
        S_WAIT_LOW: begin
          if (sync_in[i]) begin
            state_d[i] = S_HIGH;
            cnt_d[i]   = '0;
          end else if (tick) begin
            if (cnt_q[i] == CntLast) begin
              state_d[i] = S_LOW;
              cnt_d[i]   = '0;
              fall_d[i]  = 1'b1;
            end else begin
              cnt_d[i] = cnt_q[i] + 1'b1;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= S_LOW;
        cnt_q[i]   <= '0;
      end
      rise_q <= '0;
      fall_q <= '0;
      any_q  <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      rise_q <= rise_d;
      fall_q <= fall_d;
      any_q  <= |(rise_d | fall_d);
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      clean_out[i] = state_q[i][1];
    end
  end

  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;
  assign any_event  = any_q;

endmodule

// File: tb/tb_gpio_debounce.sv
// Directed bench for gpio_debounce: per-cycle vector table for the main scenarios, plus
// hand-written sequences for abort-on-tick and reset mid-debounce.
module tb_gpio_debounce;

  logic       clk;
  logic       rst;
  logic [8:0] raw_in;
  logic [8:0] clean_out;
  logic [8:0] rise_pulse;
  logic [8:0] fall_pulse;
  logic       any_event;

  int n_vec = 0;
  int n_err = 0;

  gpio_debounce #(
    .NUM_CH      (9),
    .TICK_DIV    (4),
    .STABLE_TICKS(3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .raw_in    (raw_in),
    .clean_out (clean_out),
    .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse),
    .any_event (any_event)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs held for 'span' edges; outputs after each of those edges must equal the record.
  typedef struct {
    int         span;
    logic       rst;
    logic [8:0] raw;
    logic [8:0] clean;
    logic [8:0] rise;
    logic [8:0] fall;
    logic       evt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input int span, input logic r, input logic [8:0] raw,
                              input logic [8:0] clean, input logic [8:0] rise,
                              input logic [8:0] fall, input logic evt);
    vec_t v;
    v.span  = span;
    v.rst   = r;
    v.raw   = raw;
    v.clean = clean;
    v.rise  = rise;
    v.fall  = fall;
    v.evt   = evt;
    return v;
  endfunction

  task automatic step(input logic r, input logic [8:0] raw);
    rst    = r;
    raw_in = raw;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_range(input string name, input int val, input int lo, input int hi);
    n_vec++;
    if (val < lo || val > hi) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, val, lo, hi);
    end
  endtask

  initial begin
    int rise_cnt;
    int fall_cnt;
    int clean_seen;
    int lat;

    rst    = 1'b1;
    raw_in = '0;

    // Edge numbering relative to last reset edge R=0: ticks consumed at edges 4, 8, 12, ...
    // A raw change before edge T is seen by the FSM at T+2; acceptance on the 3rd tick after.
    tbl.push_back(mk(2,  1'b1, 9'h000, 9'h000, 9'h000, 9'h000, 1'b0)); // reset
    tbl.push_back(mk(9,  1'b0, 9'h000, 9'h000, 9'h000, 9'h000, 1'b0)); // edges 1-9
    tbl.push_back(mk(14, 1'b0, 9'h021, 9'h000, 9'h000, 9'h000, 1'b0)); // press ch0,ch5 @10
    tbl.push_back(mk(1,  1'b0, 9'h021, 9'h021, 9'h021, 9'h000, 1'b1)); // accept @24
    tbl.push_back(mk(3,  1'b0, 9'h021, 9'h021, 9'h000, 9'h000, 1'b0));
    tbl.push_back(mk(3,  1'b0, 9'h029, 9'h021, 9'h000, 9'h000, 1'b0)); // ch3 bounce
    tbl.push_back(mk(3,  1'b0, 9'h021, 9'h021, 9'h000, 9'h000, 1'b0));
    tbl.push_back(mk(3,  1'b0, 9'h029, 9'h021, 9'h000, 9'h000, 1'b0));
    tbl.push_back(mk(3,  1'b0, 9'h021, 9'h021, 9'h000, 9'h000, 1'b0));
    tbl.push_back(mk(12, 1'b0, 9'h029, 9'h021, 9'h000, 9'h000, 1'b0)); // final rise @40
    tbl.push_back(mk(1,  1'b0, 9'h029, 9'h029, 9'h008, 9'h000, 1'b1)); // accept @52
    tbl.push_back(mk(3,  1'b0, 9'h029, 9'h029, 9'h000, 9'h000, 1'b0));
    tbl.push_back(mk(12, 1'b0, 9'h009, 9'h029, 9'h000, 9'h000, 1'b0)); // release ch5 @56
    tbl.push_back(mk(1,  1'b0, 9'h009, 9'h009, 9'h000, 9'h020, 1'b1)); // accept @68
    tbl.push_back(mk(3,  1'b0, 9'h009, 9'h009, 9'h000, 9'h000, 1'b0));
    tbl.push_back(mk(2,  1'b1, 9'h000, 9'h000, 9'h000, 9'h000, 1'b0)); // reset, R=73
    tbl.push_back(mk(11, 1'b0, 9'h1FF, 9'h000, 9'h000, 9'h000, 1'b0)); // all press @74
    tbl.push_back(mk(1,  1'b0, 9'h1FF, 9'h1FF, 9'h1FF, 9'h000, 1'b1)); // accept @85
    tbl.push_back(mk(3,  1'b0, 9'h1FF, 9'h1FF, 9'h000, 9'h000, 1'b0));
    tbl.push_back(mk(12, 1'b0, 9'h000, 9'h1FF, 9'h000, 9'h000, 1'b0)); // all release @89
    tbl.push_back(mk(1,  1'b0, 9'h000, 9'h000, 9'h000, 9'h1FF, 1'b1)); // accept @101
    tbl.push_back(mk(3,  1'b0, 9'h000, 9'h000, 9'h000, 9'h000, 1'b0));

    foreach (tbl[i]) begin
      for (int c = 0; c < tbl[i].span; c++) begin
        step(tbl[i].rst, tbl[i].raw);
        n_vec++;
        if ({clean_out, rise_pulse, fall_pulse, any_event} !==
            {tbl[i].clean, tbl[i].rise, tbl[i].fall, tbl[i].evt}) begin
          n_err++;
          $display("FAIL vec%0d.%0d: clean/rise/fall/any got %h/%h/%h/%b want %h/%h/%h/%b",
                   i, c, clean_out, rise_pulse, fall_pulse, any_event,
                   tbl[i].clean, tbl[i].rise, tbl[i].fall, tbl[i].evt);
        end
      end
    end

    // Abort on tick: ch2 enters WAIT_HIGH at R+3, cnt=2 after R+8; sync_in drops at R+12 tick.
    step(1'b1, 9'h000);
    step(1'b1, 9'h000);
    rise_cnt   = 0;
    fall_cnt   = 0;
    clean_seen = 0;
    for (int k = 1; k <= 24; k++) begin
      step(1'b0, (k <= 9) ? 9'h004 : 9'h000);
      rise_cnt   += int'(rise_pulse[2]);
      fall_cnt   += int'(fall_pulse[2]);
      clean_seen |= int'(clean_out[2]);
    end
    chk("abort_rise_count", rise_cnt, 0);
    chk("abort_fall_count", fall_cnt, 0);
    chk("abort_clean", clean_seen, 0);

    // After the abort the channel must debounce a fresh press normally.
    lat = 0;
    for (int k = 1; k <= 20 && lat == 0; k++) begin
      step(1'b0, 9'h004);
      if (rise_pulse[2]) lat = k;
    end
    chk_range("abort_repress_latency", lat, 11, 14);
    chk("abort_repress_clean", clean_out, 9'h004);

    // Reset mid-debounce: ch1 in WAIT_HIGH with cnt=1 after R+4, reset at R+5.
    step(1'b1, 9'h000);
    step(1'b1, 9'h000);
    rise_cnt = 0;
    for (int k = 1; k <= 4; k++) begin
      step(1'b0, 9'h002);
      rise_cnt += int'(rise_pulse[1]);
    end
    chk("rstmid_pre_rise", rise_cnt, 0);
    step(1'b1, 9'h002);
    chk("rstmid_outputs", {clean_out, rise_pulse, fall_pulse, any_event}, 0);
    lat      = 0;
    fall_cnt = 0;
    for (int k = 1; k <= 20 && lat == 0; k++) begin
      step(1'b0, 9'h002);
      fall_cnt += int'(|fall_pulse);
      if (rise_pulse[1]) lat = k;
    end
    chk_range("rstmid_reaccept_latency", lat, 11, 14);
    chk("rstmid_rise_vector", rise_pulse, 9'h002);
    chk("rstmid_any_event", any_event, 1'b1);
    chk("rstmid_no_fall", fall_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
